// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq_ctrl: iterative MUL/DIVU/REMU sequencer driving the shared ALU.  |
// | Optional macro ALU_SEQ_EARLY_TERM_EN: MUL stops once the multiplier is 0.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic             busy,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_control,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_c
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_mul_it = 2'd1;
  localparam logic [1:0] c_div_it = 2'd2;
  localparam logic [1:0] c_done   = 2'd3;

  localparam logic [1:0] c_op_mul  = 2'b00;
  localparam logic [1:0] c_op_divu = 2'b01;
  localparam logic [1:0] c_op_remu = 2'b10;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;

  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  // r_hi holds acc (MUL) or rem (DIV); r_lo holds mplier or quo; r_opnd holds mcand or dvsr.
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_opnd;
  logic             r_is_rem;
  logic [XLEN-1:0]  r_rsp_data;

  logic [XLEN-1:0]  w_shifted;
  logic             w_sub_ok;
  logic [XLEN-1:0]  w_rem_next;
  logic [XLEN-1:0]  w_quo_next;
  logic [XLEN-1:0]  w_acc_next;
  logic             w_last_cnt;
  logic             w_mul_last;

  assign w_shifted  = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
  // A set msb means the shifted remainder is at least 2^XLEN, so it always exceeds the divisor.
  assign w_sub_ok   = r_hi[XLEN-1] | alu_c;
  assign w_rem_next = w_sub_ok ? alu_result : w_shifted;
  assign w_quo_next = {r_lo[XLEN-2:0], w_sub_ok};
  assign w_acc_next = r_lo[0] ? alu_result : r_hi;
  assign w_last_cnt = (r_cnt == c_cnt_one);

`ifdef ALU_SEQ_EARLY_TERM_EN
  assign w_mul_last = w_last_cnt | (r_lo[XLEN-1:1] == '0);
`else
  assign w_mul_last = w_last_cnt;
`endif

  assign req_ready = (r_state == c_idle);
  assign rsp_valid = (r_state == c_done);
  assign busy      = (r_state == c_mul_it) | (r_state == c_div_it);
  assign rsp_data  = r_rsp_data;

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = c_alu_add;
    case (r_state)
      c_mul_it: begin
        alu_a       = r_hi;
        alu_b       = r_opnd;
        alu_control = c_alu_add;
      end
      c_div_it: begin
        alu_a       = w_shifted;
        alu_b       = r_opnd;
        alu_control = c_alu_sub;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= c_idle;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_is_rem   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (req_valid) begin
            r_cnt    <= c_cnt_init;
            r_is_rem <= (req_op == c_op_remu);
            case (req_op)
              c_op_mul: begin
                r_hi    <= '0;
                r_lo    <= req_b;
                r_opnd  <= req_a;
                r_state <= c_mul_it;
              end
              c_op_divu, c_op_remu: begin
                if (req_b == '0) begin
                  r_rsp_data <= (req_op == c_op_divu) ? '1 : req_a;
                  r_state    <= c_done;
                end else begin
                  r_hi    <= '0;
                  r_lo    <= req_a;
                  r_opnd  <= req_b;
                  r_state <= c_div_it;
                end
              end
              default: begin
                r_rsp_data <= '0;
                r_state    <= c_done;
              end
            endcase
          end
        end
        c_mul_it: begin
          r_hi   <= w_acc_next;
          r_opnd <= r_opnd << 1;
          r_lo   <= r_lo >> 1;
          r_cnt  <= r_cnt - c_cnt_one;
          if (w_mul_last) begin
            r_rsp_data <= w_acc_next;
            r_state    <= c_done;
          end
        end
        c_div_it: begin
          r_hi  <= w_rem_next;
          r_lo  <= w_quo_next;
          r_cnt <= r_cnt - c_cnt_one;
          if (w_last_cnt) begin
            r_rsp_data <= r_is_rem ? w_rem_next : w_quo_next;
            r_state    <= c_done;
          end
        end
        c_done: begin
          if (rsp_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_seq_ctrl: directed vector bench for alu_seq_ctrl with ALU model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_c;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALU_SEQ_EARLY_TERM_EN
  localparam bit c_early = 1'b1;
`else
  localparam bit c_early = 1'b0;
`endif

  alu_seq_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // Reference ALU: add, and subtract with carry meaning a >= b unsigned.
  always_comb begin
    alu_result = '0;
    alu_c      = 1'b0;
    case (alu_control)
      3'b000: {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: begin
        alu_result = alu_a - alu_b;
        alu_c      = (alu_a >= alu_b);
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[14];

  function automatic int mul_lat(input logic [31:0] b);
    int h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return c_early ? h + 1 : 32;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = ~op;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h0BAD_F00D;
  endtask

  // Starts at the falling edge after the accept edge; counts edges until rsp_valid.
  task automatic wait_rsp(output int lat, output int busy_cyc, output int bad_div_ctrl,
                          output int overlap);
    lat = 0; busy_cyc = 0; bad_div_ctrl = 0; overlap = 0;
    while (!rsp_valid && lat < 100) begin
      if (busy) busy_cyc++;
      if (busy && req_ready) overlap++;
      if (busy && alu_control != 3'b000 && alu_control != 3'b001) bad_div_ctrl++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_div_ctrl(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              output int sub_cycles);
    start_op(op, a, b);
    sub_cycles = 0;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      if (busy && alu_control == 3'b001) sub_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, bc, bad, ovl, sub;

    vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'h0000_002A, mul_lat(32'd6),          "mul_7x6"};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, mul_lat(32'hFFFF_FFFF),  "mul_ffx_ff"};
    vecs[2]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 32,                      "divu_ff_1"};
    vecs[3]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32,                      "remu_8_ff"};
    vecs[4]  = '{2'b01, 32'd100,        32'd7,          32'd14,        32,                      "divu_100_7"};
    vecs[5]  = '{2'b10, 32'd100,        32'd7,          32'd2,         32,                      "remu_100_7"};
    vecs[6]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF, 0,                       "divu_by0"};
    vecs[7]  = '{2'b10, 32'd5,          32'd0,          32'd5,         0,                       "remu_by0"};
    vecs[8]  = '{2'b11, 32'd5,          32'd3,          32'd0,         0,                       "illegal_op"};
    vecs[9]  = '{2'b00, 32'd5,          32'd1,          32'd5,         mul_lat(32'd1),          "mul_5x1"};
    vecs[10] = '{2'b00, 32'd5,          32'h8000_0000,  32'h8000_0000, mul_lat(32'h8000_0000),  "mul_5x80"};
    vecs[11] = '{2'b00, 32'h1234_5678,  32'd0,          32'd0,         mul_lat(32'd0),          "mul_x0"};
    vecs[12] = '{2'b01, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE, 32,                      "divu_deadbeef"};
    vecs[13] = '{2'b00, 32'h0001_0000,  32'h0001_0000,  32'd0,         mul_lat(32'h0001_0000),  "mul_overflow"};

    reset_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_b", alu_b, 32'd0);
    chk("reset_alu_ctrl", {29'd0, alu_control}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsp(lat, bc, bad, ovl);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_data"}, rsp_data, vecs[i].exp);
      chk({vecs[i].name, "_busy_cycles"}, bc, vecs[i].lat);
      chk({vecs[i].name, "_busy_ready_overlap"}, ovl, 0);
      chk({vecs[i].name, "_done_alu_ctrl"}, {29'd0, alu_control}, 32'd0);
      finish_op();
    end

    // Divide must issue subtract on every iteration cycle.
    run_div_ctrl(2'b01, 32'd100, 32'd7, sub);
    chk("div_alu_sub_cycles", sub, 32);
    finish_op();

    // Hold the response for 10 cycles with a competing request.
    start_op(2'b01, 32'd100, 32'd7);
    wait_rsp(lat, bc, bad, ovl);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd3; req_b = 32'd5;
    for (int i = 0; i < 10; i++) begin
      chk("stall_rsp_data", rsp_data, 32'd14);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("release_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat, bc, bad, ovl);
    chk("after_stall_mul_latency", lat, mul_lat(32'd5));
    chk("after_stall_mul_data", rsp_data, 32'd15);
    finish_op();

    // Reset in the middle of a divide discards it.
    start_op(2'b01, 32'h0000_FFFF, 32'd3);
    repeat (14) @(negedge clk);
    chk("midop_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midreset_rsp_data", rsp_data, 32'd0);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid || busy) bc++;
      @(negedge clk);
    end
    chk("midreset_no_rsp", bc, 0);
    start_op(2'b00, 32'd3, 32'd3);
    wait_rsp(lat, bc, bad, ovl);
    chk("post_reset_mul_latency", lat, mul_lat(32'd3));
    chk("post_reset_mul_data", rsp_data, 32'd9);
    finish_op();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Iterative multiply/divide sequencer for the multi-cycle datapath.
- Drives the shared 32-bit ALU's operand and control inputs for one iteration per cycle.
- Implements MUL (low word), DIVU and REMU using only ALU add (3'b000), ALU subtract (3'b001) and the ALU carry flag.
- Sits beside the main control FSM; the FSM hands it a request and stalls until the response handshake completes.

Parameters:
- XLEN, 32, operand/result width; must equal the ALU width (only 32 is supported).
- CNT_W, 6, iteration counter width; must be at least clog2(XLEN)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  00=MUL, 01=DIVU, 10=REMU, 11=illegal.
- req_a  in  XLEN  multiplicand / dividend.
- req_b  in  XLEN  multiplier / divisor.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  XLEN  result.
- busy  out  1  high in MUL_IT or DIV_IT.
- alu_a  out  XLEN  ALU operand a.
- alu_b  out  XLEN  ALU operand b.
- alu_control  out  3  ALU operation select.
- alu_result  in  XLEN  ALU result, combinational in the same cycle.
- alu_c  in  1  ALU carry out; for subtract, 1 means a >= b unsigned.

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE, counter=0, all internal registers=0, rsp_valid=0, rsp_data=0, busy=0.
  - Applies in any state. An in-flight operation is discarded and no response is produced.
- States: IDLE, MUL_IT, DIV_IT, DONE.
- IDLE:
  - req_ready=1, alu_a=0, alu_b=0, alu_control=3'b000.
  - Accept when req_valid & req_ready. Call the accept edge N.
  - MUL: acc=0, mcand=req_a, mplier=req_b, cnt=XLEN; go to MUL_IT.
  - DIVU/REMU with req_b!=0: rem=0, quo=req_a, dvsr=req_b, cnt=XLEN; go to DIV_IT.
  - DIVU/REMU with req_b==0: go to DONE. rsp_data=0xFFFFFFFF for DIVU, req_a for REMU.
  - req_op=11: go to DONE with rsp_data=0.
- MUL_IT, one iteration per cycle:
  - Drive alu_a=acc, alu_b=mcand, alu_control=000.
  - If mplier[0], acc<=alu_result. Then mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt-1.
  - When cnt==1 this cycle, go to DONE with rsp_data = the final acc value.
  - Overflow beyond XLEN bits is discarded.
- DIV_IT, restoring division:
  - shifted = {rem[XLEN-2:0], quo[XLEN-1]}; msb = rem[XLEN-1].
  - Drive alu_a=shifted, alu_b=dvsr, alu_control=001.
  - If msb | alu_c: rem<=alu_result, quo<={quo[XLEN-2:0],1}.
  - Else: rem<=shifted, quo<={quo[XLEN-2:0],0}.
  - cnt<=cnt-1. On the last iteration go to DONE; rsp_data = quo (DIVU) or rem (REMU).
- Latency:
  - MUL/DIVU/REMU: rsp_valid first high in the cycle after edge N+XLEN, i.e. 32 iteration cycles.
  - Divide-by-zero and illegal op: rsp_valid high in the cycle after edge N.
- DONE:
  - rsp_valid=1; rsp_data is stable until accepted.
  - On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid the next cycle.
  - req_ready=0 throughout DONE; there is no back-to-back bypass.
- ALU outputs in DONE are the same as in IDLE.
- busy and req_ready are never high together.
- req_a, req_b and req_op are sampled only at accept; later changes are ignored.

Optional Feature:
- Macro: ALU_SEQ_EARLY_TERM_EN.
- Defined: in MUL_IT, if the shifted mplier value would be 0 after this iteration, go to DONE immediately.
  - MUL latency becomes (index of highest set bit of req_b)+1 iterations; req_b==0 takes 1 iteration.
  - Division latency is unchanged.
- Undefined: MUL always takes XLEN iterations.

Test Plan:
- MUL 7 x 6 -> rsp_data=0x0000002A; rsp_valid first high exactly 32 cycles after the accept cycle; busy high for those 32 cycles.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001. Then DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF (exercises the msb path); REMU 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2. During DIV_IT, check alu_control=001 on every cycle.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, both with rsp_valid 1 cycle after accept. req_op=11 -> 0.
- Hold rsp_ready=0 for 10 cycles in DONE -> rsp_data stable and req_ready=0 while req_valid=1; release -> IDLE, then the next request is accepted. Separately, assert reset_n=0 at iteration 15 of a DIVU -> IDLE, no rsp_valid, and a following MUL 3 x 3 returns 9.
- With ALU_SEQ_EARLY_TERM_EN: MUL 5 x 1 -> 5 after 1 iteration; MUL 5 x 0x80000000 -> 0x80000000 after 32 iterations.
